// File: rtl/core_pkg.sv
// Shared core definitions: memory-stage FSM states, active-low strobe levels
// and the instruction class encoding carried on Dmem1ALUOUT from ID/EX.
package core_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam logic ALU_OP = 1'b0;
    localparam logic MEM_OP = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access; flags the edge on
// which the count reaches TIMEOUT so the FSM can abort on that same edge.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [3:0] LIMIT = 4'(TIMEOUT);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 4'd0;
        end else if (en_i) begin
            count_d = count_q + 4'd1;
        end
    end

    // Expired is asserted for the increment that lands the counter on LIMIT.
    assign expired_o = en_i && ((count_q + 4'd1) == LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and data-memory access stage: issues the memory
// handshake, stalls upstream while an access is outstanding, registers writeback.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [4:0]        ex_rd,
    input  logic              ex_RegWrite,
    input  logic              Dmem1ALUOUT,
    input  logic              DmemREB,
    input  logic              DmemWEB,
    output logic              mem_stall,
    output logic [DATA_W-1:0] DmemAddr,
    output logic [DATA_W-1:0] DmemWData,
    output logic              DmemREB_o,
    output logic              DmemWEB_o,
    input  logic              DmemReady,
    input  logic [DATA_W-1:0] DmemRData,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    mem_state_e        state_q, state_d;
    logic              reb_q, reb_d;
    logic              web_q, web_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        pend_rd_q, pend_rd_d;
    logic              pend_we_q, pend_we_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              err_q, err_d;

    logic tmr_clr;
    logic tmr_en;
    logic tmr_expired;
    logic rd_req;
    logic wr_req;
    logic rd_writable;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    assign rd_req      = (DmemREB == STROBE_ON);
    assign wr_req      = (DmemWEB == STROBE_ON);
    assign rd_writable = ex_RegWrite && (ex_rd != 5'd0);

    always_comb begin
        state_d    = state_q;
        reb_d      = reb_q;
        web_d      = web_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pend_rd_d  = pend_rd_q;
        pend_we_d  = pend_we_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        err_d      = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (rd_req && wr_req) begin
                        err_d = 1'b1;
                    end else if ((Dmem1ALUOUT == MEM_OP) && (rd_req || wr_req)) begin
                        // Address and store data are frozen here for the whole access.
                        state_d   = ACCESS;
                        reb_d     = DmemREB;
                        web_d     = DmemWEB;
                        addr_d    = ALUResult;
                        wdata_d   = StoreData;
                        pend_rd_d = ex_rd;
                        pend_we_d = rd_req && rd_writable;
                        tmr_clr   = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = rd_writable;
                        wb_rd_d    = ex_rd;
                        wb_data_d  = ALUResult;
                    end
                end
            end
            ACCESS: begin
                tmr_en = !DmemReady;
                if (DmemReady) begin
                    state_d    = IDLE;
                    reb_d      = STROBE_OFF;
                    web_d      = STROBE_OFF;
                    wb_valid_d = 1'b1;
                    wb_we_d    = pend_we_q;
                    wb_rd_d    = pend_rd_q;
                    if (reb_q == STROBE_ON) begin
                        wb_data_d = DmemRData;
                    end
                end else if (tmr_expired) begin
                    state_d = IDLE;
                    reb_d   = STROBE_OFF;
                    web_d   = STROBE_OFF;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            reb_q      <= STROBE_OFF;
            web_q      <= STROBE_OFF;
            addr_q     <= '0;
            wdata_q    <= '0;
            pend_rd_q  <= 5'd0;
            pend_we_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            reb_q      <= reb_d;
            web_q      <= web_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pend_rd_q  <= pend_rd_d;
            pend_we_q  <= pend_we_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign mem_stall = (state_q == ACCESS);
    assign DmemAddr  = addr_q;
    assign DmemWData = wdata_q;
    assign DmemREB_o = reb_q;
    assign DmemWEB_o = web_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: writebacks are predicted into a
// scoreboard queue when a bundle is driven and retired when wb_valid pulses.
module tb_mem_access_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ex_valid;
    logic [31:0] ALUResult;
    logic [31:0] StoreData;
    logic [4:0]  ex_rd;
    logic        ex_RegWrite;
    logic        Dmem1ALUOUT;
    logic        DmemREB;
    logic        DmemWEB;
    logic        mem_stall;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWData;
    logic        DmemREB_o;
    logic        DmemWEB_o;
    logic        DmemReady;
    logic [31:0] DmemRData;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   err_pulses = 0;

    mem_access_stage #(.DATA_W(32), .TIMEOUT(15)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ex_valid    (ex_valid),
        .ALUResult   (ALUResult),
        .StoreData   (StoreData),
        .ex_rd       (ex_rd),
        .ex_RegWrite (ex_RegWrite),
        .Dmem1ALUOUT (Dmem1ALUOUT),
        .DmemREB     (DmemREB),
        .DmemWEB     (DmemWEB),
        .mem_stall   (mem_stall),
        .DmemAddr    (DmemAddr),
        .DmemWData   (DmemWData),
        .DmemREB_o   (DmemREB_o),
        .DmemWEB_o   (DmemWEB_o),
        .DmemReady   (DmemReady),
        .DmemRData   (DmemRData),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mem_err     (mem_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic we, input logic [31:0] data,
                        input logic chk_data);
        exp_t e;
        e.rd = rd;
        e.we = we;
        e.data = data;
        e.chk_data = chk_data;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge CLK);
        #1;
        if (mem_err) err_pulses++;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                chk1("wb_unexpected", wb_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk1("wb_we", wb_we, e.we);
                if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
        end
    endtask

    task automatic drive_idle();
        ex_valid    = 1'b0;
        ALUResult   = 32'd0;
        StoreData   = 32'd0;
        ex_rd       = 5'd0;
        ex_RegWrite = 1'b0;
        Dmem1ALUOUT = 1'b0;
        DmemREB     = 1'b1;
        DmemWEB     = 1'b1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic memop, input logic reb, input logic web);
        ex_valid    = 1'b1;
        ALUResult   = alu;
        StoreData   = sd;
        ex_rd       = rd;
        ex_RegWrite = rw;
        Dmem1ALUOUT = memop;
        DmemREB     = reb;
        DmemWEB     = web;
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_stall"}, mem_stall, 1'b0);
        chk1({tag, "_reb"}, DmemREB_o, 1'b1);
        chk1({tag, "_web"}, DmemWEB_o, 1'b1);
        chk1({tag, "_wbv"}, wb_valid, 1'b0);
        chk1({tag, "_wbwe"}, wb_we, 1'b0);
        chk1({tag, "_err"}, mem_err, 1'b0);
        chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wbdata"}, wb_data, 32'd0);
        chk({tag, "_addr"}, DmemAddr, 32'd0);
        chk({tag, "_wdata"}, DmemWData, 32'd0);
    endtask

    initial begin
        int n_low;
        int n_stall;
        int n_wait;
        int err_before;

        RST_N = 1'b0;
        DmemReady = 1'b0;
        DmemRData = 32'd0;
        drive_idle();
        #12;
        check_reset_values("rst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        tick();

        // ALU op
        drive(32'h0000_0042, 32'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        push(5'd5, 1'b1, 32'h0000_0042, 1'b1);
        tick();
        chk1("alu_wbv", wb_valid, 1'b1);
        chk1("alu_stall", mem_stall, 1'b0);
        drive_idle();
        tick();
        chk1("alu_wbv_pulse", wb_valid, 1'b0);

        // Back-to-back ALU ops, including rd=0 and a memory-class bundle with no strobe
        drive(32'h0000_1111, 32'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        push(5'd1, 1'b1, 32'h0000_1111, 1'b1);
        tick();
        drive(32'h0000_2222, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        push(5'd0, 1'b0, 32'h0000_2222, 1'b1);
        tick();
        drive(32'h0000_3333, 32'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        push(5'd2, 1'b1, 32'h0000_3333, 1'b1);
        tick();
        chk1("mem_nostrobe_stall", mem_stall, 1'b0);
        drive_idle();
        tick();

        // LW 0x100, three wait cycles
        DmemRData = 32'hDEAD_BEEF;
        drive(32'h0000_0100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        push(5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1);
        n_low = 0;
        n_stall = 0;
        tick();
        chk("lw_addr", DmemAddr, 32'h0000_0100);
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            if (DmemREB_o == 1'b0) n_low++;
            if (mem_stall) n_stall++;
            DmemReady = (i == 3);
            if (i < 3) tick();
        end
        tick();
        DmemReady = 1'b0;
        chk1("lw_wbv", wb_valid, 1'b1);
        chk1("lw_reb_release", DmemREB_o, 1'b1);
        chk("lw_reb_low_cycles", n_low, 4);
        chk("lw_stall_cycles", n_stall, 4);
        tick();

        // SW 0x200 zero-wait, ready held high (ignored while IDLE), then ADD
        DmemReady = 1'b1;
        drive(32'h0000_0200, 32'h0000_1234, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        push(5'd3, 1'b0, 32'd0, 1'b0);
        tick();
        chk1("sw_web_low", DmemWEB_o, 1'b0);
        chk1("sw_stall", mem_stall, 1'b1);
        chk("sw_addr", DmemAddr, 32'h0000_0200);
        chk("sw_wdata", DmemWData, 32'h0000_1234);
        drive(32'h0000_0077, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        push(5'd9, 1'b1, 32'h0000_0077, 1'b1);
        tick();
        chk1("sw_web_release", DmemWEB_o, 1'b1);
        chk1("sw_wbv", wb_valid, 1'b1);
        tick();
        chk1("add_after_sw_wbv", wb_valid, 1'b1);
        drive_idle();
        DmemReady = 1'b0;
        tick();

        // LW with no ready: timeout
        err_before = err_pulses;
        drive(32'h0000_0300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive_idle();
        n_wait = 0;
        while (DmemREB_o == 1'b0 && n_wait < 20) begin
            tick();
            n_wait++;
        end
        chk("to_wait_edges", n_wait, 15);
        chk1("to_err", mem_err, 1'b1);
        chk1("to_stall", mem_stall, 1'b0);
        chk1("to_wbv", wb_valid, 1'b0);
        tick();
        chk1("to_err_pulse", mem_err, 1'b0);
        chk("to_err_count", err_pulses - err_before, 1);

        // LW where ready lands on the timeout edge: completes without error
        DmemRData = 32'h0BAD_F00D;
        drive(32'h0000_0304, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        push(5'd6, 1'b1, 32'h0BAD_F00D, 1'b1);
        tick();
        drive_idle();
        for (int i = 0; i < 14; i++) tick();
        DmemReady = 1'b1;
        tick();
        DmemReady = 1'b0;
        chk1("race_wbv", wb_valid, 1'b1);
        chk1("race_err", mem_err, 1'b0);
        tick();

        // Reset during the second wait cycle of a store
        drive(32'h0000_0400, 32'h0000_0055, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk1("rst_sw_web_low", DmemWEB_o, 1'b0);
        drive_idle();
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk1("midrst_wbv", wb_valid, 1'b0);

        // Illegal bundle
        err_before = err_pulses;
        drive(32'h0000_0500, 32'h0000_0066, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk1("ill_err", mem_err, 1'b1);
        chk1("ill_reb", DmemREB_o, 1'b1);
        chk1("ill_web", DmemWEB_o, 1'b1);
        chk1("ill_stall", mem_stall, 1'b0);
        chk1("ill_wbv", wb_valid, 1'b0);
        drive_idle();
        tick();
        chk1("ill_err_pulse", mem_err, 1'b0);
        chk("ill_err_count", err_pulses - err_before, 1);

        // LW to x0
        DmemReady = 1'b1;
        DmemRData = 32'hCAFE_0001;
        drive(32'h0000_0600, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        push(5'd0, 1'b0, 32'hCAFE_0001, 1'b1);
        tick();
        chk1("lwx0_reb_low", DmemREB_o, 1'b0);
        drive_idle();
        tick();
        chk1("lwx0_wbv", wb_valid, 1'b1);
        DmemReady = 1'b0;
        tick();
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
